// File: rtl/mem_requester_if.sv
// Core-side request/response handshake plus the memory port of one core's
// requester. The requester uses the master modport; the core and memory
// environment use the slave modport.
interface mem_requester_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDRESS_BITS-1:0] req_address;
   logic [DATA_WIDTH-1:0]   req_data;

   logic                    resp_valid;
   logic                    resp_ready;
   logic                    resp_write;
   logic [ADDRESS_BITS-1:0] resp_address;
   logic [DATA_WIDTH-1:0]   resp_data;

   logic                    mem_read;
   logic                    mem_write;
   logic [ADDRESS_BITS-1:0] mem_address;
   logic [DATA_WIDTH-1:0]   mem_in_data;
   logic [ADDRESS_BITS-1:0] mem_out_addr;
   logic [DATA_WIDTH-1:0]   mem_out_data;
   logic                    mem_valid;
   logic                    mem_ready;

   modport master (
      input  req_valid, req_write, req_address, req_data, resp_ready,
             mem_out_addr, mem_out_data, mem_valid, mem_ready,
      output req_ready, resp_valid, resp_write, resp_address, resp_data,
             mem_read, mem_write, mem_address, mem_in_data
   );

   modport slave (
      output req_valid, req_write, req_address, req_data, resp_ready,
             mem_out_addr, mem_out_data, mem_valid, mem_ready,
      input  req_ready, resp_valid, resp_write, resp_address, resp_data,
             mem_read, mem_write, mem_address, mem_in_data
   );
endinterface

// File: rtl/mem_requester.sv
// Initiator front end for one core's memory port: queues core load/store
// requests, issues them one at a time, and returns one in-order response each.
module mem_requester #(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int QUEUE_DEPTH  = 4,
   parameter int READ_LATENCY = 1,
   parameter int TIMEOUT      = 15
) (
   input  logic            clock,
   input  logic            reset,
   mem_requester_if.master bus,
   output logic            error,
   input  logic            report
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = $clog2(READ_LATENCY + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic                    write;
      logic [ADDRESS_BITS-1:0] address;
      logic [DATA_WIDTH-1:0]   data;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   req_t             fifo [QUEUE_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   state_t           state;
   logic             cur_write;
   logic [LAT_W-1:0] lat_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             push, pop;
   req_t             head;

   // report only drives simulation printouts; the hardware has nothing to show
   logic unused_report;
   assign unused_report = report ^ (CORE == 0);

   // No push-while-full bypass: a full queue refuses even if a pop is due
   assign bus.req_ready = !reset && (count != CNT_W'(QUEUE_DEPTH));
   assign push = bus.req_valid && bus.req_ready;
   assign pop  = (state == IDLE) && (count != '0) && bus.mem_ready;
   assign head = fifo[rd_ptr];

   // Request storage; occupancy gates every read, so entries need no reset
   always_ff @(posedge clock) begin
      if (push)
         fifo[wr_ptr] <= '{write: bus.req_write, address: bus.req_address,
                           data: bus.req_data};
   end

   // Queue pointers, issue FSM and all registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         state            <= IDLE;
         cur_write        <= 1'b0;
         lat_cnt          <= '0;
         tmo_cnt          <= '0;
         error            <= 1'b0;
         bus.mem_read     <= 1'b0;
         bus.mem_write    <= 1'b0;
         bus.mem_address  <= '0;
         bus.mem_in_data  <= '0;
         bus.resp_valid   <= 1'b0;
         bus.resp_write   <= 1'b0;
         bus.resp_address <= '0;
         bus.resp_data    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);

         case (state)
            IDLE: begin
               if (pop) begin
                  cur_write       <= head.write;
                  bus.mem_read    <= !head.write;
                  bus.mem_write   <= head.write;
                  bus.mem_address <= head.address;
                  bus.mem_in_data <= head.data;
                  tmo_cnt         <= '0;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.mem_valid) begin
                  if (cur_write) begin
                     // Store is done once accepted; echo its data back
                     bus.mem_write    <= 1'b0;
                     bus.resp_valid   <= 1'b1;
                     bus.resp_write   <= 1'b1;
                     bus.resp_address <= bus.mem_address;
                     bus.resp_data    <= bus.mem_in_data;
                     state            <= RESP;
                  end else begin
                     lat_cnt <= LAT_W'(READ_LATENCY);
                     state   <= WAIT;
                  end
               end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  // Memory never accepted: abort with a zero-data response
                  bus.mem_read     <= 1'b0;
                  bus.mem_write    <= 1'b0;
                  bus.resp_valid   <= 1'b1;
                  bus.resp_write   <= cur_write;
                  bus.resp_address <= bus.mem_address;
                  bus.resp_data    <= '0;
                  error            <= 1'b1;
                  state            <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            WAIT: begin
               if (lat_cnt == LAT_W'(1)) begin
                  // Data is kept even when the echoed address disagrees
                  bus.mem_read     <= 1'b0;
                  bus.resp_valid   <= 1'b1;
                  bus.resp_write   <= 1'b0;
                  bus.resp_address <= bus.mem_address;
                  bus.resp_data    <= bus.mem_out_data;
                  if (bus.mem_out_addr != bus.mem_address) error <= 1'b1;
                  state            <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
Initiator-side front end for the per-core memory interface. It accepts load/store requests from the core pipeline into a small FIFO and issues them one at a time on the memory port (read, write, address, in_data). It then consumes the memory's valid/out_addr/out_data and returns one response per request to the core over a valid/ready handshake.

Parameters:
CORE, 0, core index used in report output
DATA_WIDTH, 32, data word width
ADDRESS_BITS, 20, address width
QUEUE_DEPTH, 4, request FIFO entries (power of 2, >=2)
READ_LATENCY, 1, cycles from accepted read (mem_valid) to data capture (>=1)
TIMEOUT, 15, max consecutive ISSUE cycles without mem_valid before abort

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  core request present
req_ready  out  1  FIFO can accept (= !full, 0 during reset)
req_write  in  1  1=store, 0=load
req_address  in  ADDRESS_BITS  request address
req_data  in  DATA_WIDTH  store data
resp_valid  out  1  response present
resp_ready  in  1  core accepts response
resp_write  out  1  response belongs to a store
resp_address  out  ADDRESS_BITS  address of completed request
resp_data  out  DATA_WIDTH  load data (store: echoed store data; timeout: 0)
mem_read  out  1  read strobe to memory
mem_write  out  1  write strobe to memory
mem_address  out  ADDRESS_BITS  memory address
mem_in_data  out  DATA_WIDTH  memory write data
mem_out_addr  in  ADDRESS_BITS  address echoed by memory on reads
mem_out_data  in  DATA_WIDTH  memory read data
mem_valid  in  1  memory has accepted current access
mem_ready  in  1  memory idle
error  out  1  sticky: timeout or address-echo mismatch
report  in  1  print state/counters when high

Behaviour:
- Reset (synchronous, active-high): FIFO emptied, FSM->IDLE, all outputs 0 (incl. req_ready, error), counters 0. In-flight request dropped with no response. Reset dominates all other events in the same cycle.
- FIFO push on req_valid&&req_ready. Full: req_ready=0, no push (no same-cycle push-while-pop bypass). Pointers wrap modulo QUEUE_DEPTH. Occupancy counter is log2(QUEUE_DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty && mem_ready, pop head into request registers -> ISSUE. Otherwise stay. mem_read=mem_write=0.
- ISSUE: mem_read=!write, mem_write=write, mem_address and mem_in_data driven from request registers, held stable.
  - mem_valid=1 on a store -> RESP.
  - mem_valid=1 on a load -> WAIT with latency counter=READ_LATENCY.
  - mem_valid=0: increment timeout counter. At TIMEOUT consecutive cycles -> RESP with resp_data=0, error set.
- WAIT: mem_read held with same address. Counter decrements each cycle. In the cycle it reaches 1, capture mem_out_data -> RESP. If mem_out_addr != mem_address in the capture cycle, set error; data is still captured.
- RESP: strobes 0. resp_valid=1 with resp_* held stable until resp_ready. On handshake -> IDLE, so there is one bubble before the next issue.
- Latency (mem_valid immediate, mem_ready=1, empty FIFO, push at cycle t):
  - Store: ISSUE at t+2, resp_valid at t+3.
  - Load: ISSUE t+2, WAIT t+3..t+2+READ_LATENCY, resp_valid at t+3+READ_LATENCY.
- FIFO accepts requests in any FSM state. Responses are returned strictly in request order.
- error is cleared only by reset.
- Never assert mem_read and mem_write together.
- report: display cycle count, state, FIFO occupancy, mem strobes/address, error.

Test Plan:
- Store 0x00010/0xDEADBEEF, mem_valid=1 same cycle -> mem_write high 1 cycle at t+2, resp_valid t+3 with resp_write=1, resp_data=0xDEADBEEF.
- Load 0x00010, memory returns 0xDEADBEEF, out_addr=0x00010, READ_LATENCY=1 -> mem_read high 2 cycles, resp_valid t+4, resp_data=0xDEADBEEF, error=0.
- Push 5 requests back-to-back, QUEUE_DEPTH=4, resp_ready=0 -> req_ready drops after the FIFO fills. Then set resp_ready=1 -> all responses return in order, with addresses matching the pushes.
- Hold mem_valid=0 for a load -> after 15 ISSUE cycles resp_valid with resp_data=0, error=1 and sticky. The next request completes normally.
- Load with mem_out_addr=0x00014 while mem_address=0x00010 -> response delivered, error=1.
- Assert reset during WAIT with 2 requests queued -> next cycle all outputs 0, no response emitted, and a subsequent store completes with t+3 latency.
